// File: rtl/gyro_data_sequencer.sv
// Channel sequencer: snapshots all sensor channels on a load strobe and presents
// one channel at a time (manual select or timed round-robin) over valid/ready.
module gyro_data_sequencer #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 16,
  parameter int SEL_W  = 2,
  parameter int DWELL  = 50_000_000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic                   ch_load,
  input  logic                   auto_en,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   data_ready,
  input  logic                   ovr_clr,
  output logic [CH_W-1:0]        data_out,
  output logic [SEL_W-1:0]       ch_out,
  output logic                   data_valid,
  output logic                   overrun
);

  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(NUM_CH - 1);

  logic [CH_W-1:0]  snap [NUM_CH];
  logic [SEL_W-1:0] cur_ch;
  logic [SEL_W-1:0] next_ch;
  logic [SEL_W-1:0] ev_ch;
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic [CH_W-1:0]  ev_word;
  logic             sel_chg;
  logic             advance;
  logic             event_hit;
  logic             slot_free;

  always_comb begin
    next_cnt = dwell_cnt;
    next_ch  = cur_ch;
    advance  = 1'b0;
    if (auto_en) begin
      if (dwell_cnt == CNT_LAST) begin
        next_cnt = '0;
        advance  = 1'b1;
        next_ch  = (cur_ch >= LAST_CH) ? '0 : cur_ch + 1'b1;
      end else begin
        next_cnt = dwell_cnt + 1'b1;
      end
    end else begin
      next_cnt = '0;
      next_ch  = sel;
    end
  end

  // Manual changes report the channel registered on the previous edge; auto
  // advances report the channel being entered, so a load merges with it.
  always_comb begin
    ev_ch   = auto_en ? next_ch : cur_ch;
    ev_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ev_ch == SEL_W'(k)) begin
        ev_word = ch_load ? ch_data[k*CH_W +: CH_W] : snap[k];
      end
    end
    event_hit = ch_load | advance | sel_chg;
    slot_free = ~data_valid | data_ready;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
    end else if (ch_load) begin
      for (int k = 0; k < NUM_CH; k++) snap[k] <= ch_data[k*CH_W +: CH_W];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur_ch     <= '0;
      dwell_cnt  <= '0;
      sel_chg    <= 1'b0;
      data_out   <= '0;
      ch_out     <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cur_ch    <= next_ch;
      dwell_cnt <= next_cnt;
      sel_chg   <= ~auto_en & (sel != cur_ch);

      if (event_hit) begin
        if (slot_free) begin
          data_out   <= ev_word;
          ch_out     <= ev_ch;
          data_valid <= 1'b1;
        end
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end

      // A drop in the same cycle as a clear wins.
      if (event_hit && !slot_free) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gyro_data_sequencer.sv
// Self-checking bench for gyro_data_sequencer: directed vector table, scan and
// corner-case sequences, then random traffic against a behavioural model.
module tb_gyro_data_sequencer;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 16;
  localparam int SEL_W  = 2;
  localparam int DWELL  = 4;

  logic        clk;
  logic        rst_n;
  logic [63:0] ch_data;
  logic        ch_load;
  logic        auto_en;
  logic [1:0]  sel;
  logic        data_ready;
  logic        ovr_clr;

  logic [15:0] data_out;
  logic [1:0]  ch_out;
  logic        data_valid;
  logic        overrun;

  logic [15:0] s_data_out;
  logic [1:0]  s_ch_out;
  logic        s_data_valid;
  logic        s_overrun;

  int checks = 0;
  int errors = 0;

  gyro_data_sequencer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .CLK(clk), .RST_N(rst_n), .ch_data(ch_data), .ch_load(ch_load),
    .auto_en(auto_en), .sel(sel), .data_ready(data_ready), .ovr_clr(ovr_clr),
    .data_out(data_out), .ch_out(ch_out), .data_valid(data_valid), .overrun(overrun)
  );

  // Three-channel instance exercises out-of-range selection.
  gyro_data_sequencer #(.NUM_CH(3), .CH_W(CH_W), .SEL_W(SEL_W), .DWELL(DWELL)) dut_small (
    .CLK(clk), .RST_N(rst_n), .ch_data(ch_data[47:0]), .ch_load(ch_load),
    .auto_en(auto_en), .sel(sel), .data_ready(data_ready), .ovr_clr(ovr_clr),
    .data_out(s_data_out), .ch_out(s_ch_out), .data_valid(s_data_valid), .overrun(s_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference for the four-channel instance.
  int m_snap [NUM_CH];
  int m_cur, m_cnt, m_dout, m_ch;
  bit m_pend, m_dv, m_ovr;

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) m_snap[k] = 0;
    m_cur = 0; m_cnt = 0; m_dout = 0; m_ch = 0;
    m_pend = 0; m_dv = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    int  new_cur, eff, word;
    bit  adv, ev, drop;
    adv = 0;
    drop = 0;
    if (auto_en) begin
      if (m_cnt == DWELL - 1) begin
        adv = 1;
        m_cnt = 0;
        new_cur = (m_cur + 1 >= NUM_CH) ? 0 : m_cur + 1;
      end else begin
        m_cnt = m_cnt + 1;
        new_cur = m_cur;
      end
    end else begin
      m_cnt = 0;
      new_cur = int'(sel);
    end
    ev  = ch_load || adv || m_pend;
    eff = auto_en ? new_cur : m_cur;
    if (ch_load) for (int k = 0; k < NUM_CH; k++) m_snap[k] = int'(ch_data[k*16 +: 16]);
    word = (eff < NUM_CH) ? m_snap[eff] : 0;
    if (ev) begin
      if (!m_dv || data_ready) begin
        m_dout = word; m_ch = eff; m_dv = 1;
      end else begin
        drop = 1;
      end
    end else if (data_ready) begin
      m_dv = 0;
    end
    if (drop) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    m_pend = !auto_en && (int'(sel) != m_cur);
    m_cur = new_cur;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    model_step();
    #1;
    checkOutput("model_dout",  32'(data_out),   32'(m_dout));
    checkOutput("model_ch",    32'(ch_out),     32'(m_ch));
    checkOutput("model_valid", 32'(data_valid), 32'(m_dv));
    checkOutput("model_ovr",   32'(overrun),    32'(m_ovr));
  endtask

  typedef struct {
    logic        load;
    logic        use_b;
    logic [1:0]  sel;
    logic        ready;
    logic        clr;
    logic        exp_dv;
    logic [15:0] exp_dout;
    logic [1:0]  exp_ch;
    logic        exp_ovr;
  } vec_t;

  vec_t        vecs [17];
  int          exp_seq [5] = '{1, 2, 3, 0, 1};
  logic [63:0] data_a = 64'h0042_3333_2222_1111;
  logic [63:0] data_b = 64'hDDDD_CCCC_BBBB_AAAA;

  initial begin
    logic [63:0] saved;
    int          last_ev, n_ev, guard;

    vecs[0]  = '{0, 0, 2, 1, 0, 0, 16'h0000, 0, 0};
    vecs[1]  = '{0, 0, 2, 1, 0, 1, 16'h0000, 2, 0};
    vecs[2]  = '{1, 0, 2, 1, 0, 1, 16'h3333, 2, 0};
    vecs[3]  = '{0, 0, 2, 1, 0, 0, 16'h3333, 2, 0};
    vecs[4]  = '{0, 0, 3, 1, 0, 0, 16'h3333, 2, 0};
    vecs[5]  = '{0, 0, 3, 1, 0, 1, 16'h0042, 3, 0};
    vecs[6]  = '{0, 0, 3, 1, 0, 0, 16'h0042, 3, 0};
    vecs[7]  = '{1, 1, 3, 0, 0, 1, 16'hDDDD, 3, 0};
    vecs[8]  = '{1, 0, 3, 0, 0, 1, 16'hDDDD, 3, 1};
    vecs[9]  = '{0, 0, 3, 0, 0, 1, 16'hDDDD, 3, 1};
    vecs[10] = '{0, 0, 3, 1, 0, 0, 16'hDDDD, 3, 1};
    vecs[11] = '{0, 0, 3, 0, 1, 0, 16'hDDDD, 3, 0};
    vecs[12] = '{1, 0, 3, 0, 1, 1, 16'h0042, 3, 0};
    vecs[13] = '{1, 0, 3, 0, 1, 1, 16'h0042, 3, 1};
    vecs[14] = '{1, 1, 3, 1, 0, 1, 16'hDDDD, 3, 1};
    vecs[15] = '{0, 0, 3, 1, 0, 0, 16'hDDDD, 3, 1};
    vecs[16] = '{0, 0, 3, 1, 1, 0, 16'hDDDD, 3, 0};

    rst_n = 1'b0; ch_data = '0; ch_load = 0; auto_en = 0; sel = 0; data_ready = 0; ovr_clr = 0;
    model_reset();
    #12;
    rst_n = 1'b1;
    checkOutput("reset_dout",  32'(data_out),   0);
    checkOutput("reset_ch",    32'(ch_out),     0);
    checkOutput("reset_valid", 32'(data_valid), 0);
    checkOutput("reset_ovr",   32'(overrun),    0);

    for (int i = 0; i < 17; i++) begin
      ch_load    = vecs[i].load;
      ch_data    = vecs[i].load ? (vecs[i].use_b ? data_b : data_a) : {$urandom, $urandom};
      sel        = vecs[i].sel;
      data_ready = vecs[i].ready;
      ovr_clr    = vecs[i].clr;
      applyStimulus();
      checkOutput($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_dv));
      checkOutput($sformatf("vec%0d_dout", i),  32'(data_out),   32'(vecs[i].exp_dout));
      checkOutput($sformatf("vec%0d_ch", i),    32'(ch_out),     32'(vecs[i].exp_ch));
      checkOutput($sformatf("vec%0d_ovr", i),   32'(overrun),    32'(vecs[i].exp_ovr));
    end
    ch_load = 0; ovr_clr = 0;

    // Round-robin scan from channel 0.
    sel = 0; data_ready = 1;
    applyStimulus();
    applyStimulus();
    auto_en = 1;
    last_ev = -1; n_ev = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (data_valid) begin
        if (n_ev < 5) checkOutput("scan_ch", 32'(ch_out), 32'(exp_seq[n_ev]));
        if (n_ev > 0) checkOutput("scan_gap", 32'(i - last_ev), 32'(DWELL));
        last_ev = i;
        n_ev++;
      end
    end
    checkOutput("scan_count", 32'(n_ev), 5);

    // Load merged with an auto advance 0->1.
    guard = 0;
    while (!(m_cur == 0 && m_cnt == DWELL - 1) && guard < 40) begin
      applyStimulus();
      guard++;
    end
    checkOutput("merge_wait_timeout", 32'(guard < 40), 1);
    saved = {$urandom, $urandom};
    ch_data = saved; ch_load = 1;
    applyStimulus();
    ch_load = 0;
    checkOutput("merge_dout",  32'(data_out),   32'(saved[31:16]));
    checkOutput("merge_ch",    32'(ch_out),     1);
    checkOutput("merge_valid", 32'(data_valid), 1);
    checkOutput("merge_ovr",   32'(overrun),    0);
    applyStimulus();
    checkOutput("merge_single", 32'(data_valid), 0);

    // Out-of-range selection on the three-channel instance.
    auto_en = 0; sel = 3;
    applyStimulus();
    applyStimulus();
    checkOutput("oor_dout",  32'(s_data_out),   0);
    checkOutput("oor_ch",    32'(s_ch_out),     3);
    checkOutput("oor_valid", 32'(s_data_valid), 1);
    auto_en = 1;
    for (int i = 0; i < DWELL; i++) applyStimulus();
    checkOutput("oor_wrap_ch",    32'(s_ch_out),     0);
    checkOutput("oor_wrap_valid", 32'(s_data_valid), 1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(31) == 0) auto_en = ~auto_en;
      if ($urandom_range(3) == 0) sel = 2'($urandom_range(3));
      ch_data    = {$urandom, $urandom};
      ch_load    = ($urandom_range(5) == 0);
      data_ready = $urandom_range(1) == 1;
      ovr_clr    = ($urandom_range(11) == 0);
      applyStimulus();
    end

    // Asynchronous reset while a word is pending.
    auto_en = 0; ch_load = 1; data_ready = 0; ovr_clr = 0; ch_data = data_a;
    applyStimulus();
    ch_load = 0;
    checkOutput("areset_pre_valid", 32'(data_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("areset_dout",  32'(data_out),   0);
    checkOutput("areset_ch",    32'(ch_out),     0);
    checkOutput("areset_valid", 32'(data_valid), 0);
    checkOutput("areset_ovr",   32'(overrun),    0);
    #10;
    rst_n = 1'b1; sel = 0;
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gyro_data_sequencer.md
# gyro_data_sequencer

Parametrised, registered channel sequencer for the sensor-readout path. It latches all sensor channels coherently on a load strobe and presents one channel at a time to the downstream display/UART logic over a valid/ready handshake. The channel is chosen either by a manual `sel` input or by an automatic round-robin scan with a programmable dwell time. It sits between the SPI sensor-read controller and the display/serial formatter, and it adds stall protection and overrun reporting.

## Interface
- `NUM_CH`, 4: number of channels, 2..2**SEL_W.
- `CH_W`, 16: width of each channel word.
- `SEL_W`, 2: width of the channel index.
- `DWELL`, 50_000_000: auto-scan cycles per channel, at least 1. Counter width is clog2(DWELL).

Ports:
- `CLK`  in  1  system clock; all flops on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `ch_data`  in  NUM_CH*CH_W  flattened channel bus; channel k occupies bits [k*CH_W +: CH_W].
- `ch_load`  in  1  one-cycle strobe that captures all of `ch_data` into the snapshot bank.
- `auto_en`  in  1  1 = round-robin scan; 0 = manual selection via `sel`.
- `sel`  in  SEL_W  manual channel index.
- `data_ready`  in  1  downstream accepts the word.
- `ovr_clr`  in  1  clears `overrun`.
- `data_out`  out  CH_W  selected snapshot word.
- `ch_out`  out  SEL_W  index of the channel in `data_out`.
- `data_valid`  out  1  `data_out`/`ch_out` hold an unconsumed word.
- `overrun`  out  1  sticky: an update event was dropped.

## Operation
**Snapshot bank**
- NUM_CH registers of CH_W bits each.
- All are written in the same edge when `ch_load`=1.
- They read 0 after reset.

**Current channel `cur_ch`**
- Manual mode (`auto_en`=0):
  - `cur_ch` <= `sel` every cycle.
  - The dwell counter is held at 0.
  - If `sel` >= NUM_CH, the word is all-zero and `ch_out`=`sel`.
- Auto mode (`auto_en`=1):
  - The dwell counter counts 0..DWELL-1.
  - At DWELL-1 the counter returns to 0 and `cur_ch` advances by one.
  - `cur_ch` wraps from NUM_CH-1 to 0; an out-of-range `cur_ch` also advances to 0.
- On 0->1 of `auto_en`, scanning starts from the current `cur_ch` with the counter at 0.

**Update events** (at most one per cycle; simultaneous causes merge into one event):
- `ch_load`=1.
- `cur_ch` changes, from a manual `sel` change or an auto advance.
- The event word is the post-update snapshot of the post-update channel. For `ch_load`, that means the incoming `ch_data` slice is bypassed straight to the output.

**Output slot**
- The slot is free when `data_valid`=0, or when `data_valid`=1 and `data_ready`=1 (transfer this cycle).
- Event with the slot free: `data_out`/`ch_out` are loaded and `data_valid` <= 1.
- Event with the slot busy: the word is dropped, `overrun` <= 1, and `data_out`/`ch_out`/`data_valid` are unchanged.
- Transfer with no event: `data_valid` <= 0 and `data_out` holds its last value.
- While `data_valid`=1 and `data_ready`=0, `data_out` and `ch_out` are stable.

**`overrun`**
- Set as described above.
- Cleared by `ovr_clr`; a set and a clear in the same cycle leave it at 1.

## Timing
- Reset values: `data_out`=0, `ch_out`=0, `data_valid`=0, `overrun`=0, `cur_ch`=0, dwell counter=0, snapshot bank=0.
- Reset applied mid-transfer discards the pending word with no handshake.
- Latency: 1 cycle. An event sampled at edge n shows on `data_out`/`data_valid` after edge n.
- Manual `sel` change: `cur_ch` is registered at edge n and the event takes effect at edge n+1, so 2 cycles from `sel` to `data_valid`.
- Auto period: exactly DWELL cycles between channel advances, independent of handshake stalls.
- `ready` may be high without `valid`; this has no effect.
- `ch_load` while `data_valid`=1 and `data_ready`=1 is a transfer plus a new word: `data_valid` stays 1 with the new data.

## Test plan
1. **Reset and manual select.** Reset, then `sel`=2, `ch_load` with ch0..3 = 0x1111/0x2222/0x3333/0x0042, `data_ready`=1. Required: `data_out`=0x3333, `ch_out`=2, `data_valid` high for 1 cycle. Then `sel`=3: `data_out`=0x0042.
2. **Auto scan.** DWELL=4, `auto_en`=1, `ready`=1. Required: `ch_out` sequence 1,2,3,0,1 with advances spaced exactly 4 cycles apart, and `data_valid` pulsing once per advance.
3. **Backpressure and overrun.** `data_ready`=0, `ch_load` twice with different data. Required: the first word is held stable, `overrun`=1 after the second load, and `data_out` still equals the first word. Raising `ready` gives one transfer and `valid` drops. Then `ovr_clr` brings `overrun` to 0.
4. **Simultaneous events.** `ch_load` in the same cycle as an auto advance 0->1. Required: a single event, with `data_out` = the new ch1 value and `overrun`=0. Transfer plus load in the same cycle: `valid` stays 1 with the new word.
5. **Out-of-range select.** NUM_CH=3, `sel`=3. Required: `data_out`=0, `ch_out`=3. In auto mode starting from `cur_ch`=3, the next channel is 0.
6. **Asynchronous reset.** Assert `RST_N` low mid-cycle while `data_valid`=1. Required: all outputs go to 0 immediately, without waiting for `CLK`.
